// File: rtl/seq_detect_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
package seq_detect_pkg;

    localparam logic [2:0] DEFAULT_PATTERN = 3'b101;

    typedef enum logic {
        MODE_NON_OVERLAP = 1'b0,
        MODE_OVERLAP     = 1'b1
    } match_mode_e;

    function automatic int unsigned state_width(input int unsigned pat_width);
        return $clog2(pat_width + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detect_n.sv
// Serial detector for a run-time programmable PAT_WIDTH-bit pattern with
// overlap control, valid qualification and a saturating match counter.
module seq_detect_n
    import seq_detect_pkg::*;
#(
    parameter int unsigned           PAT_WIDTH = 3,
    parameter logic [PAT_WIDTH-1:0]  PAT_RESET = DEFAULT_PATTERN,
    parameter int unsigned           CNT_WIDTH = 8,
    localparam int unsigned          SW        = state_width(PAT_WIDTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in,
    input  logic                 in_valid,
    input  logic                 overlap,
    input  logic                 cfg_load,
    input  logic [PAT_WIDTH-1:0] cfg_pattern,
    input  logic                 clr_count,
    output logic                 match,
    output logic [CNT_WIDTH-1:0] match_count,
    output logic [SW-1:0]        state_out
);

    localparam logic [SW-1:0] FULL = SW'(PAT_WIDTH);

    logic [PAT_WIDTH-1:0] pat;
    logic [PAT_WIDTH-1:0] hist;
    logic [SW-1:0]        fill;
    logic [PAT_WIDTH-1:0] hist_next;
    logic [SW-1:0]        fill_next;
    logic                 sample;
    logic                 hit;
    match_mode_e          mode;

    assign mode = match_mode_e'(overlap);

    always_comb begin
        sample    = in_valid && !cfg_load;
        hist_next = {hist[PAT_WIDTH-2:0], in};
        fill_next = (fill == FULL) ? fill : fill + 1'b1;
        hit       = sample && (fill_next == FULL) && (hist_next == pat);
    end

    // Non-overlapping mode keeps the history but demands PAT_WIDTH fresh bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pat   <= PAT_RESET;
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else if (cfg_load) begin
            pat   <= cfg_pattern;
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else if (in_valid) begin
            hist  <= hist_next;
            fill  <= (hit && mode == MODE_NON_OVERLAP) ? '0 : fill_next;
            match <= hit;
        end else begin
            match <= 1'b0;
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_count (
        .clock (clock),
        .reset (reset),
        .clr   (clr_count),
        .inc   (hit),
        .count (match_count)
    );

    assign state_out = fill;

endmodule

// File: doc/seq_detect_n.md
Name: seq_detect_n

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed 2-bit-state "101" detector FSM.
- Adds run-time programmable pattern of PAT_WIDTH bits, selectable overlapping/non-overlapping matching, input-valid qualification, saturating match counter and debug progress output.
- Sits on a serial input stream in front of control logic that consumes single-cycle match pulses.

Parameters:
- PAT_WIDTH, 3: pattern length in bits; legal range 2..32.
- PAT_RESET, 3'b101: pattern loaded at reset; width PAT_WIDTH.
- CNT_WIDTH, 8: width of match_count.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset: state clears when reset=0, independent of clock.
- in  input  1  serial data bit.
- in_valid  input  1  in sampled only when 1.
- overlap  input  1  1 = overlapping matches, 0 = non-overlapping; sampled every valid cycle.
- cfg_load  input  1  load cfg_pattern this cycle.
- cfg_pattern  input  PAT_WIDTH  new pattern; bit PAT_WIDTH-1 is the first bit received.
- clr_count  input  1  synchronous clear of match_count.
- match  output  1  registered one-cycle match pulse.
- match_count  output  CNT_WIDTH  saturating count of matches.
- state_out  output  $clog2(PAT_WIDTH+1)  debug: current fill count.

Behaviour:
- Internal state:
  - pattern register pat.
  - history shift register hist, PAT_WIDTH bits.
  - fill counter fill, 0..PAT_WIDTH: the number of valid bits accumulated since the last reset, cfg_load, or non-overlap match.
- Reset (reset=0, asynchronous):
  - pat=PAT_RESET, hist=0, fill=0.
  - match=0, match_count=0, state_out=0.
- Valid sample (in_valid=1, cfg_load=0):
  - hist <= {hist[PAT_WIDTH-2:0], in}.
  - fill increments by 1, saturating at PAT_WIDTH.
- Match condition, evaluated on the post-shift values: fill_next==PAT_WIDTH and hist_next==pat.
- Match pulse:
  - match <= 1 on the edge that samples the last pattern bit.
  - match is high for exactly the following cycle.
  - Equivalent to the Moore output of the legacy detector.
- Overlap handling after a match:
  - overlap=1: fill stays at PAT_WIDTH, so the next valid bit may complete another match.
  - overlap=0: fill <= 0 and hist is retained; a new match needs PAT_WIDTH fresh bits.
- in_valid=0: hist and fill hold; match <= 0. Gaps in in_valid are transparent to detection.
- cfg_load=1:
  - pat <= cfg_pattern, hist <= 0, fill <= 0, match <= 0.
  - A concurrent valid sample is discarded.
  - match_count is unaffected.
- match_count:
  - Increments by 1 on each match, saturating at all-ones; no wrap.
  - clr_count=1 forces 0 the next cycle and takes priority over a simultaneous increment.
  - The match pulse itself still occurs when clr_count coincides with a match.
- state_out = fill.
- Reset asserted mid-sequence: partial progress is lost and detection restarts from fill=0 after reset release.
- Latency: 1 cycle from the last sampled bit to match.

Decomposition:
- Shared package seq_detect_pkg:
  - Default-pattern constant.
  - Function for state_out width: clog2 of PAT_WIDTH+1.
- One natural sub-module, sat_counter: parametric-width saturating counter with sync clear and increment.
- History, fill and match logic stay in the top module.

Test Plan:
1. Defaults, overlap=1, stream 1,0,1,0,1 all valid -> match high in the cycle after the 3rd and after the 5th bit; match_count=2; state_out=3 after the 3rd bit.
2. Same stream with overlap=0 -> single match after the 3rd bit; state_out=0 after the match, 2 after the 5th bit; match_count=1.
3. Stream 1,0,1 with in_valid=0 bubbles between bits -> one match, one cycle after the final valid 1; no match during bubbles.
4. cfg_load with cfg_pattern=3'b110 while in_valid=1 -> that sample is discarded and state_out=0; then 1,1,0 -> match; old pattern 101 no longer matches.
5. Force match_count to 8'hFF via 255 overlapping matches, then one more match -> count stays 8'hFF; clr_count coincident with a match -> count 0, match still pulses.
6. Drive reset=0 asynchronously between clock edges after bits 1,0 -> all outputs 0 immediately; after release, bit 1 alone gives no match; state_out=1.
